alu_cmd_sequencer: RTL and testbench
====================================

// Module: alu_cmd_sequencer
// PURPOSE
//  Initiator-side controller for the 4-bit combinational ALU: accepts commands over a
//  valid/ready port and reads operands from a 4x4 register file. Drives A/B/OP to the
//  ALU, captures Y and N/Z/C/V, and writes Y back to the file. Returns the result and
//  flags on a valid/ready response port. Sits between the command source and the ALU.
// PARAMETERS
//  DW    4  data width (matches ALU A/B/Y)
//  NREG  4  register-file entries; index width RW = $clog2(NREG) = 2
//  OPW   3  ALU opcode width
// PORTS
//  clk        in   1    single clock, rising edge
//  rst_n      in   1    asynchronous, active-low reset
//  cmd_valid  in   1    command present
//  cmd_ready  out  1    sequencer can accept a command
//  cmd_op     in   OPW  ALU opcode (AND,OR,XOR,SHR,SHL,SUB,ADD,SLT = 0..7)
//  cmd_load   in   1    1 = write cmd_imm to rd; ALU not used
//  cmd_imm_en in   1    1 = operand B is cmd_imm instead of rf[rb]
//  cmd_imm    in   DW   immediate value
//  cmd_rd     in   RW   destination index
//  cmd_ra     in   RW   source A index
//  cmd_rb     in   RW   source B index
//  alu_a      out  DW   to ALU A (registered)
//  alu_b      out  DW   to ALU B (registered)
//  alu_op     out  OPW  to ALU OP (registered)
//  alu_y      in   DW   from ALU Y
//  alu_nzcv   in   4    from ALU {N,Z,C,V}
//  rsp_valid  out  1    response present
//  rsp_ready  in   1    consumer accepts response
//  rsp_y      out  DW   result written to rd
//  rsp_nzcv   out  4    flag register after the command
//  busy       out  1    state != IDLE
// BEHAVIOUR
//  Reset values: all outputs 0 except cmd_ready = 0 during reset and 1 after release
//   (IDLE). rf[*] = 0, flag register = 0, FSM = IDLE.
//  FSM states are IDLE, EXEC and RESP; cmd_ready = (state == IDLE); no other overlap.
//  IDLE: on cmd_valid & cmd_ready, latch the command.
//   ALU command: load alu_a = rf[ra], alu_b = imm_en ? imm : rf[rb], alu_op = op.
//   Go to EXEC.
//  EXEC, exactly 1 cycle (the ALU is combinational): at the closing edge, capture the result.
//   ALU command: rf[rd] <= alu_y, flags <= alu_nzcv, rsp_y <= alu_y.
//   Load command: rf[rd] <= imm and rsp_y <= imm; flags unchanged; alu_* hold.
//   Then rsp_nzcv <= new flags and go to RESP.
//  RESP: rsp_valid = 1, with rsp_y and rsp_nzcv held stable until rsp_ready.
//   On rsp_valid & rsp_ready, go to IDLE.
//  Latency: accept edge k -> rsp_valid high from edge k+1. Best throughput is 1 cmd / 3 clk.
//  Operands are read at acceptance, so the next command sees the prior write-back (no hazard).
//  rd == ra or rd == rb: reads use old values and the write lands at end of EXEC.
//  alu_* keep their last value outside EXEC. Widths are fixed at DW; no extension.
//  Flags are forwarded verbatim from the ALU; no recomputation.
//  cmd_* are ignored outside IDLE. rsp_ready is ignored when rsp_valid = 0.
//  Async reset in any state aborts the in-flight command: no response, no rf write.
//  Outputs return to reset values immediately.
// STRUCTURE
//  Shared package alu_defs holds:
//   - OP_AND..OP_SLT localparams (3'b000..3'b111)
//   - flag bit indices N=3, Z=2, C=1, V=0
//   - FSM state encodings
//  One sub-module, alu_regfile: NREG x DW, 2 async read ports, 1 sync write port,
//   async active-low clear. The FSM, operand muxing and response registers stay in this module.
// TESTING
//  Bench instantiates the real 4-bit ALU on alu_*.
//  1 load r0=7, r1=9, then ADD r2=r0+r1 -> rsp_y=4'h0, rsp_nzcv=4'b0110; rf[2]=0.
//  2 SUB r3=r0-r1 -> rsp_y=4'hE, rsp_nzcv=4'b1000.
//    Then SLT r3=r0<r1 -> rsp_y=4'h1.
//  3 AND r0 with imm_en, imm=4'h3, rd=r0 -> rsp_y=4'h3 (rd==ra).
//    Following SHL r1=r0<<1 (imm) -> 4'h6.
//  4 hold rsp_ready=0 for 5 cycles -> rsp_valid stays 1 with rsp_y/rsp_nzcv stable,
//    cmd_ready=0, and a second cmd_valid is not accepted.
//  5 load after ADD -> rsp_nzcv unchanged from ADD (0110); alu_* unchanged.
//  6 assert rst_n=0 during EXEC -> rsp_valid never rises, rf all 0, cmd_ready=1 after release.

Source files
------------

// File: rtl/alu_cmd_sequencer_pkg.sv
// Shared widths, ALU opcodes, flag bit positions and sequencer FSM states.
// Latency: n/a (definitions only).
// Backpressure: n/a (definitions only).
package alu_defs;

  localparam int DW   = 4;
  localparam int NREG = 4;
  localparam int RW   = $clog2(NREG);
  localparam int OPW  = 3;

  localparam logic [OPW-1:0] OP_AND = 3'b000;
  localparam logic [OPW-1:0] OP_OR  = 3'b001;
  localparam logic [OPW-1:0] OP_XOR = 3'b010;
  localparam logic [OPW-1:0] OP_SHR = 3'b011;
  localparam logic [OPW-1:0] OP_SHL = 3'b100;
  localparam logic [OPW-1:0] OP_SUB = 3'b101;
  localparam logic [OPW-1:0] OP_ADD = 3'b110;
  localparam logic [OPW-1:0] OP_SLT = 3'b111;

  // Bit positions inside the {N,Z,C,V} flag nibble.
  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_t;

endpackage

// File: rtl/alu_cmd_sequencer_if.sv
// Command and response handshake bundle between a command source and the sequencer.
// Latency: n/a (wires only).
// Backpressure: valid/ready on both the command and the response channel.
interface alu_cmd_sequencer_if;
  import alu_defs::*;

  logic           cmd_valid;
  logic           cmd_ready;
  logic [OPW-1:0] cmd_op;
  logic           cmd_load;
  logic           cmd_imm_en;
  logic [DW-1:0]  cmd_imm;
  logic [RW-1:0]  cmd_rd;
  logic [RW-1:0]  cmd_ra;
  logic [RW-1:0]  cmd_rb;

  logic           rsp_valid;
  logic           rsp_ready;
  logic [DW-1:0]  rsp_y;
  logic [3:0]     rsp_nzcv;

  modport master (
    output cmd_valid, cmd_op, cmd_load, cmd_imm_en, cmd_imm, cmd_rd, cmd_ra, cmd_rb,
    output rsp_ready,
    input  cmd_ready, rsp_valid, rsp_y, rsp_nzcv
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_load, cmd_imm_en, cmd_imm, cmd_rd, cmd_ra, cmd_rb,
    input  rsp_ready,
    output cmd_ready, rsp_valid, rsp_y, rsp_nzcv
  );

endinterface

// File: rtl/alu_regfile.sv
// NREG x DW register file: two asynchronous read ports, one synchronous write port.
// Latency: reads are combinational; a write is visible after the writing edge.
// Backpressure: none, a write is taken on every cycle wr_en is high.
module alu_regfile #(
  parameter int DW   = 4,
  parameter int NREG = 4,
  localparam int RW  = $clog2(NREG)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [RW-1:0] ra_addr,
  output logic [DW-1:0] ra_dat,
  input  logic [RW-1:0] rb_addr,
  output logic [DW-1:0] rb_dat,
  input  logic          wr_en,
  input  logic [RW-1:0] wr_addr,
  input  logic [DW-1:0] wr_dat
);

  logic [DW-1:0] mem [NREG];

  assign ra_dat = mem[ra_addr];
  assign rb_dat = mem[rb_addr];

  // Storage: cleared by reset, one entry written per enabled edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) mem[i] <= '0;
    end else if (wr_en) begin
      mem[wr_addr] <= wr_dat;
    end
  end

endmodule

// File: rtl/alu_cmd_sequencer.sv
// Sequences register-file commands through an external combinational ALU and writes back.
// Latency: accept edge k -> rsp_valid from edge k+1; best throughput one command per 3 clocks.
// Backpressure: cmd_ready only in IDLE; the response is held stable until rsp_ready.
module alu_cmd_sequencer
  import alu_defs::*;
(
  input  logic               clk,
  input  logic               rst_n,
  alu_cmd_sequencer_if.slave bus,
  output logic [DW-1:0]      alu_a,
  output logic [DW-1:0]      alu_b,
  output logic [OPW-1:0]     alu_op,
  input  logic [DW-1:0]      alu_y,
  input  logic [3:0]         alu_nzcv,
  output logic               busy
);

  state_t        state_q, state_d;
  logic          ready_q;
  logic          accept;
  logic          load_q;
  logic [DW-1:0] imm_q;
  logic [RW-1:0] rd_q;
  logic [DW-1:0] rf_a, rf_b;
  logic          wr_en;
  logic [DW-1:0] wr_dat;
  logic [DW-1:0] rsp_y_q;
  logic [3:0]    flags_q;

  // Ready is registered so it is low throughout reset and rises on the first edge after it.
  assign accept        = bus.cmd_valid && ready_q;
  assign bus.cmd_ready = ready_q;
  assign bus.rsp_valid = (state_q == ST_RESP);
  assign bus.rsp_y     = rsp_y_q;
  assign bus.rsp_nzcv  = flags_q;
  assign busy          = (state_q != ST_IDLE);

  // Write-back lands at the closing edge of EXEC; loads bypass the ALU.
  assign wr_en  = (state_q == ST_EXEC);
  assign wr_dat = load_q ? imm_q : alu_y;

  alu_regfile #(.DW(DW), .NREG(NREG)) u_regfile (
    .clk     (clk),
    .rst_n   (rst_n),
    .ra_addr (bus.cmd_ra),
    .ra_dat  (rf_a),
    .rb_addr (bus.cmd_rb),
    .rb_dat  (rf_b),
    .wr_en   (wr_en),
    .wr_addr (rd_q),
    .wr_dat  (wr_dat)
  );

  // FSM state register plus the registered IDLE indication used as cmd_ready.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ready_q <= (state_d == ST_IDLE);
    end
  end

  // Next-state: EXEC is always a single cycle since the ALU is combinational.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (accept) state_d = ST_EXEC;
      ST_EXEC: state_d = ST_RESP;
      ST_RESP: if (bus.rsp_ready) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Latch the command at acceptance; operands are read here so a write-back from the
  // previous command is already visible, and a load leaves the ALU inputs untouched.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      load_q <= 1'b0;
      imm_q  <= '0;
      rd_q   <= '0;
      alu_a  <= '0;
      alu_b  <= '0;
      alu_op <= '0;
    end else if (accept) begin
      load_q <= bus.cmd_load;
      imm_q  <= bus.cmd_imm;
      rd_q   <= bus.cmd_rd;
      if (!bus.cmd_load) begin
        alu_a  <= rf_a;
        alu_b  <= bus.cmd_imm_en ? bus.cmd_imm : rf_b;
        alu_op <= bus.cmd_op;
      end
    end
  end

  // Capture the result and flags at the end of EXEC; loads keep the previous flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_y_q <= '0;
      flags_q <= '0;
    end else if (state_q == ST_EXEC) begin
      rsp_y_q <= wr_dat;
      if (!load_q) flags_q <= alu_nzcv;
    end
  end

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Bench for alu_cmd_sequencer with a behavioural 4-bit ALU attached to the alu_* ports.
// Latency: n/a.
// Backpressure: exercised by holding rsp_ready low.
module tb_alu_cmd_sequencer;
  import alu_defs::*;

  typedef struct packed {
    logic       load;
    logic       imm_en;
    logic [2:0] op;
    logic [3:0] imm;
    logic [1:0] rd;
    logic [1:0] ra;
    logic [1:0] rb;
  } cmd_t;

  typedef struct packed {
    cmd_t       c;
    logic [3:0] y;
    logic [3:0] nzcv;
    logic [3:0] a;
    logic [3:0] b;
    logic [2:0] op;
  } vec_t;

  logic       clk;
  logic       rst_n;
  logic [3:0] alu_a, alu_b, alu_y, alu_nzcv;
  logic [2:0] alu_op;
  logic       busy;
  logic [7:0] alu_out;

  alu_cmd_sequencer_if sq_if ();

  alu_cmd_sequencer dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (sq_if),
    .alu_a    (alu_a),
    .alu_b    (alu_b),
    .alu_op   (alu_op),
    .alu_y    (alu_y),
    .alu_nzcv (alu_nzcv),
    .busy     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // The 4-bit ALU: result plus {N,Z,C,V}; C/V meaningful for ADD, C = no-borrow for SUB.
  function automatic logic [7:0] alu_fn(input logic [2:0] op, input logic [3:0] a, input logic [3:0] b);
    logic [4:0] s;
    logic [3:0] y;
    logic       c, v;
    c = 1'b0; v = 1'b0; y = 4'h0; s = 5'h0;
    case (op)
      OP_AND: y = a & b;
      OP_OR:  y = a | b;
      OP_XOR: y = a ^ b;
      OP_SHR: y = a >> b;
      OP_SHL: y = a << b;
      OP_SUB: begin y = a - b; c = (a >= b); end
      OP_ADD: begin
        s = {1'b0, a} + {1'b0, b};
        y = s[3:0];
        c = s[4];
        v = (a[3] == b[3]) && (y[3] != a[3]);
      end
      default: y = (a < b) ? 4'h1 : 4'h0;
    endcase
    return {y, y[3], (y == 4'h0), c, v};
  endfunction

  always_comb begin
    alu_out  = alu_fn(alu_op, alu_a, alu_b);
    alu_y    = alu_out[7:4];
    alu_nzcv = alu_out[3:0];
  end

  int         total, bad;
  logic [3:0] m_rf [4];
  logic [3:0] m_flags, m_a, m_b;
  logic [2:0] m_op;
  vec_t       vecs [14];
  cmd_t       c, c2;
  logic [3:0] ey, en;
  bit         seen;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic cmd_t ld(input logic [1:0] rd, input logic [3:0] imm);
    cmd_t r;
    r = '0; r.load = 1'b1; r.rd = rd; r.imm = imm;
    return r;
  endfunction

  function automatic cmd_t ar(input logic [2:0] op, input logic [1:0] rd, input logic [1:0] ra,
                              input logic [1:0] rb, input logic imm_en, input logic [3:0] imm);
    cmd_t r;
    r.load = 1'b0; r.imm_en = imm_en; r.op = op; r.imm = imm; r.rd = rd; r.ra = ra; r.rb = rb;
    return r;
  endfunction

  function automatic vec_t mkv(input cmd_t cc, input logic [3:0] y, input logic [3:0] nz,
                               input logic [3:0] a, input logic [3:0] b, input logic [2:0] op);
    vec_t v;
    v.c = cc; v.y = y; v.nzcv = nz; v.a = a; v.b = b; v.op = op;
    return v;
  endfunction

  // Reference: register array and flag nibble updated per command, reads before the write.
  task automatic model_apply(input cmd_t cc, output logic [3:0] y, output logic [3:0] nz);
    logic [7:0] r;
    if (cc.load) begin
      y = cc.imm;
      m_rf[cc.rd] = cc.imm;
    end else begin
      m_a  = m_rf[cc.ra];
      m_b  = cc.imm_en ? cc.imm : m_rf[cc.rb];
      m_op = cc.op;
      r    = alu_fn(m_op, m_a, m_b);
      y    = r[7:4];
      m_flags = r[3:0];
      m_rf[cc.rd] = y;
    end
    nz = m_flags;
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4; i++) m_rf[i] = 4'h0;
    m_flags = 4'h0; m_a = 4'h0; m_b = 4'h0; m_op = 3'h0;
  endtask

  task automatic drive_cmd(input cmd_t cc);
    sq_if.cmd_load   = cc.load;
    sq_if.cmd_imm_en = cc.imm_en;
    sq_if.cmd_op     = cc.op;
    sq_if.cmd_imm    = cc.imm;
    sq_if.cmd_rd     = cc.rd;
    sq_if.cmd_ra     = cc.ra;
    sq_if.cmd_rb     = cc.rb;
  endtask

  // Called #1 after an edge; returns #1 after the accepting edge (EXEC cycle).
  task automatic issue(input cmd_t cc);
    int n;
    bit acc;
    n = 0; acc = 1'b0;
    drive_cmd(cc);
    sq_if.cmd_valid = 1'b1;
    while (!acc && n < 20) begin
      acc = sq_if.cmd_ready;
      @(posedge clk);
      n++;
    end
    #1;
    sq_if.cmd_valid = 1'b0;
    check("accept", 32'(acc), 32'd1);
  endtask

  task automatic wait_rsp(input string nm);
    int n;
    n = 0;
    do begin
      @(posedge clk); #1; n++;
    end while (!sq_if.rsp_valid && n < 10);
    check({nm, " latency"}, 32'(n), 32'd1);
  endtask

  task automatic release_rsp(input string nm);
    sq_if.rsp_ready = 1'b1;
    @(posedge clk); #1;
    sq_if.rsp_ready = 1'b0;
    check({nm, " ready after rsp"}, 32'(sq_if.cmd_ready), 32'd1);
  endtask

  task automatic check_rsp(input string nm, input logic [3:0] y, input logic [3:0] nz,
                           input logic [3:0] a, input logic [3:0] b, input logic [2:0] op);
    check({nm, " rsp_y"},    32'(sq_if.rsp_y),    32'(y));
    check({nm, " rsp_nzcv"}, 32'(sq_if.rsp_nzcv), 32'(nz));
    check({nm, " alu_a"},    32'(alu_a),          32'(a));
    check({nm, " alu_b"},    32'(alu_b),          32'(b));
    check({nm, " alu_op"},   32'(alu_op),         32'(op));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    total = 0; bad = 0;
    rst_n = 1'b0;
    sq_if.cmd_valid = 1'b0;
    sq_if.rsp_ready = 1'b0;
    drive_cmd('0);
    model_reset();

    vecs[0]  = mkv(ld(2'd0, 4'h7),                          4'h7, 4'b0000, 4'h0, 4'h0, 3'd0);
    vecs[1]  = mkv(ld(2'd1, 4'h9),                          4'h9, 4'b0000, 4'h0, 4'h0, 3'd0);
    vecs[2]  = mkv(ar(OP_ADD, 2'd2, 2'd0, 2'd1, 1'b0, 4'h0), 4'h0, 4'b0110, 4'h7, 4'h9, OP_ADD);
    vecs[3]  = mkv(ld(2'd3, 4'hA),                          4'hA, 4'b0110, 4'h7, 4'h9, OP_ADD);
    vecs[4]  = mkv(ar(OP_SUB, 2'd3, 2'd0, 2'd1, 1'b0, 4'h0), 4'hE, 4'b1000, 4'h7, 4'h9, OP_SUB);
    vecs[5]  = mkv(ar(OP_SLT, 2'd3, 2'd0, 2'd1, 1'b0, 4'h0), 4'h1, 4'b0000, 4'h7, 4'h9, OP_SLT);
    vecs[6]  = mkv(ar(OP_AND, 2'd0, 2'd0, 2'd0, 1'b1, 4'h3), 4'h3, 4'b0000, 4'h7, 4'h3, OP_AND);
    vecs[7]  = mkv(ar(OP_SHL, 2'd1, 2'd0, 2'd0, 1'b1, 4'h1), 4'h6, 4'b0000, 4'h3, 4'h1, OP_SHL);
    vecs[8]  = mkv(ar(OP_ADD, 2'd1, 2'd0, 2'd1, 1'b0, 4'h0), 4'h9, 4'b1001, 4'h3, 4'h6, OP_ADD);
    vecs[9]  = mkv(ar(OP_ADD, 2'd2, 2'd1, 2'd0, 1'b1, 4'h8), 4'h1, 4'b0011, 4'h9, 4'h8, OP_ADD);
    vecs[10] = mkv(ld(2'd3, 4'h5),                          4'h5, 4'b0011, 4'h9, 4'h8, OP_ADD);
    vecs[11] = mkv(ar(OP_XOR, 2'd0, 2'd3, 2'd2, 1'b0, 4'h0), 4'h4, 4'b0000, 4'h5, 4'h1, OP_XOR);
    vecs[12] = mkv(ar(OP_OR,  2'd2, 2'd2, 2'd0, 1'b0, 4'h0), 4'h5, 4'b0000, 4'h1, 4'h4, OP_OR);
    vecs[13] = mkv(ar(OP_SHR, 2'd3, 2'd1, 2'd0, 1'b1, 4'h2), 4'h2, 4'b0000, 4'h9, 4'h2, OP_SHR);

    // Reset state.
    repeat (2) @(posedge clk);
    #1;
    check("reset cmd_ready", 32'(sq_if.cmd_ready), 32'd0);
    check("reset rsp_valid", 32'(sq_if.rsp_valid), 32'd0);
    check("reset busy",      32'(busy),            32'd0);
    check("reset rsp_y",     32'(sq_if.rsp_y),     32'd0);
    check("reset rsp_nzcv",  32'(sq_if.rsp_nzcv),  32'd0);
    check("reset alu_a",     32'(alu_a),           32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("post-reset cmd_ready", 32'(sq_if.cmd_ready), 32'd1);

    // Directed vector table.
    for (int i = 0; i < 14; i++) begin
      issue(vecs[i].c);
      model_apply(vecs[i].c, ey, en);
      wait_rsp($sformatf("vec%0d", i));
      check_rsp($sformatf("vec%0d", i), vecs[i].y, vecs[i].nzcv, vecs[i].a, vecs[i].b, vecs[i].op);
      release_rsp($sformatf("vec%0d", i));
    end

    // Response backpressure: output frozen, no second command taken.
    c = ar(OP_SUB, 2'd2, 2'd1, 2'd0, 1'b0, 4'h0);
    issue(c);
    model_apply(c, ey, en);
    wait_rsp("bp");
    c2 = ld(2'd0, 4'hF);
    drive_cmd(c2);
    sq_if.cmd_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      check($sformatf("bp%0d rsp_valid", k), 32'(sq_if.rsp_valid), 32'd1);
      check($sformatf("bp%0d rsp_y", k),     32'(sq_if.rsp_y),     32'(ey));
      check($sformatf("bp%0d rsp_nzcv", k),  32'(sq_if.rsp_nzcv),  32'(en));
      check($sformatf("bp%0d cmd_ready", k), 32'(sq_if.cmd_ready), 32'd0);
    end
    sq_if.cmd_valid = 1'b0;
    release_rsp("bp");
    seen = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      if (sq_if.rsp_valid || busy) seen = 1'b1;
    end
    check("bp second cmd ignored", 32'(seen), 32'd0);

    // Randomised commands against the reference model.
    for (int i = 0; i < 150; i++) begin
      c.load   = ($urandom_range(0, 3) == 0);
      c.imm_en = 1'($urandom_range(0, 1));
      c.op     = 3'($urandom_range(0, 7));
      c.imm    = 4'($urandom_range(0, 15));
      c.rd     = 2'($urandom_range(0, 3));
      c.ra     = 2'($urandom_range(0, 3));
      c.rb     = 2'($urandom_range(0, 3));
      repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
      issue(c);
      model_apply(c, ey, en);
      wait_rsp($sformatf("rnd%0d", i));
      repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
      check_rsp($sformatf("rnd%0d", i), ey, en, m_a, m_b, m_op);
      release_rsp($sformatf("rnd%0d", i));
    end

    // Reset during EXEC aborts the command.
    c = ar(OP_ADD, 2'd1, 2'd0, 2'd2, 1'b1, 4'h5);
    issue(c);
    rst_n = 1'b0;
    #1;
    check("abort busy",      32'(busy),            32'd0);
    check("abort cmd_ready", 32'(sq_if.cmd_ready), 32'd0);
    check("abort alu_a",     32'(alu_a),           32'd0);
    check("abort alu_b",     32'(alu_b),           32'd0);
    check("abort rsp_y",     32'(sq_if.rsp_y),     32'd0);
    seen = sq_if.rsp_valid;
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      if (sq_if.rsp_valid) seen = 1'b1;
    end
    check("abort no response", 32'(seen), 32'd0);
    check("abort cmd_ready after release", 32'(sq_if.cmd_ready), 32'd1);
    model_reset();

    // Register file cleared: rf[i] + 0 must be zero with Z set.
    for (int i = 0; i < 4; i++) begin
      c = ar(OP_ADD, 2'(i), 2'(i), 2'(i), 1'b1, 4'h0);
      issue(c);
      model_apply(c, ey, en);
      wait_rsp($sformatf("clr%0d", i));
      check_rsp($sformatf("clr%0d", i), 4'h0, 4'b0100, 4'h0, 4'h0, OP_ADD);
      release_rsp($sformatf("clr%0d", i));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
